bus_dest_regs: RTL and testbench

BUS_DEST_REGS -- requirements
Module: bus_dest_regs

---
 rtl/bus_dest_regs.sv | 81 ++++++++
 tb/tb_bus_dest_regs.sv | 104 ++++++++++
 2 files changed

// File: rtl/bus_dest_regs.sv
// Eight W-bit destination registers fed from a common bus.
// One LOAD/INC/CLR per accepted cycle, with registered Ack, Wrap and Last_dest.
module bus_dest_regs #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic [2:0]   Selection,
  input  logic [1:0]   Operation,
  input  logic         Enable,
  input  logic [W-1:0] Bus_in,
  output logic [W-1:0] Output0,
  output logic [W-1:0] Output1,
  output logic [W-1:0] Output2,
  output logic [W-1:0] Output3,
  output logic [W-1:0] Output4,
  output logic [W-1:0] Output5,
  output logic [W-1:0] Output6,
  output logic [W-1:0] Output7,
  output logic         Ack,
  output logic         Wrap,
  output logic [2:0]   Last_dest
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [W-1:0] r_regs [8];
  logic         r_ack;
  logic         r_wrap;
  logic [2:0]   r_last;

  op_e          w_op;
  logic         w_accept;
  logic [W-1:0] w_sel_val;

  always_comb begin
    w_op      = op_e'(Operation);
    w_accept  = Enable && (w_op != OP_NOP);
    w_sel_val = r_regs[Selection];
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
      r_ack  <= 1'b0;
      r_wrap <= 1'b0;
      r_last <= '0;
    end else begin
      r_ack  <= w_accept;
      r_wrap <= w_accept && (w_op == OP_INC) && (w_sel_val == '1);
      if (w_accept) begin
        r_last <= Selection;
        // Bus_in is only sampled on the LOAD branch, so X/Z elsewhere never lands in state.
        case (w_op)
          OP_LOAD: r_regs[Selection] <= Bus_in;
          OP_INC:  r_regs[Selection] <= w_sel_val + 1'b1;
          OP_CLR:  r_regs[Selection] <= '0;
          default: ;
        endcase
      end
    end
  end

  assign Output0   = r_regs[0];
  assign Output1   = r_regs[1];
  assign Output2   = r_regs[2];
  assign Output3   = r_regs[3];
  assign Output4   = r_regs[4];
  assign Output5   = r_regs[5];
  assign Output6   = r_regs[6];
  assign Output7   = r_regs[7];
  assign Ack       = r_ack;
  assign Wrap      = r_wrap;
  assign Last_dest = r_last;

endmodule

// File: tb/tb_bus_dest_regs.sv
// Randomized and directed checks of bus_dest_regs against an arithmetic reference model.
module tb_bus_dest_regs;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   sel;
  logic [1:0]   op;
  logic         en;
  logic [W-1:0] bus;
  logic [W-1:0] dout [8];
  logic         ack, wrap;
  logic [2:0]   last;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  int unsigned m_reg [8];
  int unsigned m_last;
  bit          m_ack, m_wrap;

  always #5 clk = ~clk;

  bus_dest_regs #(.W(W)) dut (
    .Clock(clk), .Reset_n(rst_n), .Selection(sel), .Operation(op),
    .Enable(en), .Bus_in(bus),
    .Output0(dout[0]), .Output1(dout[1]), .Output2(dout[2]), .Output3(dout[3]),
    .Output4(dout[4]), .Output5(dout[5]), .Output6(dout[6]), .Output7(dout[7]),
    .Ack(ack), .Wrap(wrap), .Last_dest(last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare every output.
  task automatic step(input bit r, input bit e, input int unsigned o,
                      input int unsigned s, input logic [W-1:0] b);
    bit acc;
    rst_n = r; en = e; op = o[1:0]; sel = s[2:0]; bus = b;
    @(posedge clk);
    acc = r && e && (o != 0);
    if (!r) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_ack = 0; m_wrap = 0; m_last = 0;
    end else begin
      m_ack  = acc;
      m_wrap = acc && (o == 2) && (m_reg[s] == 65535);
      if (acc) begin
        m_last = s;
        if (o == 1)      m_reg[s] = int'(b);
        else if (o == 2) m_reg[s] = (m_reg[s] + 1) % 65536;
        else             m_reg[s] = 0;
      end
    end
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("out%0d", i), 32'(dout[i]), m_reg[i]);
    chk("ack",  32'(ack),  32'(m_ack));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("last", 32'(last), m_last);
  endtask

  initial begin
    int unsigned o, s;
    logic [W-1:0] b;
    rst_n = 1'b0; en = 1'b0; op = 2'b00; sel = 3'd0; bus = '0;
    foreach (m_reg[i]) m_reg[i] = 0;
    m_ack = 0; m_wrap = 0; m_last = 0;

    step(0, 0, 0, 0, 16'h0000);
    step(1, 1, 1, 3, 16'h1234);   // load r3, Ack, Last_dest=3
    step(1, 0, 0, 0, 16'h0000);   // Ack drops
    step(1, 1, 1, 7, 16'hFFFF);
    step(1, 1, 2, 7, 16'h0000);   // wrap to zero
    step(1, 0, 0, 0, 16'h0000);
    step(1, 1, 1, 1, 16'h00AA);
    step(1, 1, 2, 1, 16'h0000);
    step(1, 1, 2, 1, 16'h0000);
    step(1, 1, 3, 1, 16'h0000);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 2, 16'hBEEF);
    step(0, 1, 1, 5, 16'h5555);   // reset wins over load
    step(1, 1, 1, 5, 16'h5555);
    for (int n = 0; n < 8; n++) step(1, 1, 1, n, 16'(n * 16'h1111));
    step(1, 1, 0, 4, 16'h0F0F);   // NOP with enable

    for (int k = 0; k < 400; k++) begin
      o = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      // Bias toward all-ones loads so INC wraps are exercised.
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if (o != 1) b = 'x;
      step($urandom_range(0, 40) != 0, $urandom_range(0, 4) != 0, o, s, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
